// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32 core.
// Owns the fetch PC and keeps saturating stall/flush event counters.
module if_id_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              PC_Write_i,
    input  logic              Stall_i,
    input  logic              Branch_i,
    input  logic [XLEN-1:0]   Branch_target_i,
    input  logic [XLEN-1:0]   Instr_i,
    output logic [XLEN-1:0]   PC_o,
    output logic [XLEN-1:0]   ID_Instr_o,
    output logic [XLEN-1:0]   ID_PC_o,
    output logic              ID_Valid_o,
    output logic [CNT_W-1:0]  Stall_cnt_o,
    output logic [CNT_W-1:0]  Flush_cnt_o
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  id_pc_q, id_pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        id_pc_d     = id_pc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (Stall_i) begin
            // Branch is ignored here; ID still holds it and re-resolves next cycle.
            if (PC_Write_i) begin
                pc_d = pc_plus4;
            end
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (Branch_i) begin
            if (PC_Write_i) begin
                pc_d = {Branch_target_i[XLEN-1:2], 2'b00};
            end
            instr_d = NOP_INSTR;
            id_pc_d = pc_q;
            valid_d = 1'b0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            instr_d = Instr_i;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            if (PC_Write_i) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            id_pc_q     <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            id_pc_q     <= id_pc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_o        = pc_q;
    assign ID_Instr_o  = instr_q;
    assign ID_PC_o     = id_pc_q;
    assign ID_Valid_o  = valid_q;
    assign Stall_cnt_o = stall_cnt_q;
    assign Flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: a behavioural instruction memory plus a
// queue of expected IF/ID contents pushed on every advance and popped after the edge.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        PC_Write_i;
    logic        Stall_i;
    logic        Branch_i;
    logic [31:0] Branch_target_i;
    logic [31:0] Instr_i;
    logic [31:0] PC_o;
    logic [31:0] ID_Instr_o;
    logic [31:0] ID_PC_o;
    logic        ID_Valid_o;
    logic [15:0] Stall_cnt_o;
    logic [15:0] Flush_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_id_instr;
    logic [31:0] exp_id_pc;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
    logic [63:0] sb_q[$];

    if_id_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .PC_Write_i      (PC_Write_i),
        .Stall_i         (Stall_i),
        .Branch_i        (Branch_i),
        .Branch_target_i (Branch_target_i),
        .Instr_i         (Instr_i),
        .PC_o            (PC_o),
        .ID_Instr_o      (ID_Instr_o),
        .ID_PC_o         (ID_PC_o),
        .ID_Valid_o      (ID_Valid_o),
        .Stall_cnt_o     (Stall_cnt_o),
        .Flush_cnt_o     (Flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign Instr_i = imem(PC_o);

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One ADVANCE edge; expected IF/ID contents go through the scoreboard queue.
    task automatic advance(input logic pcw);
        logic [63:0] e;
        Stall_i    = 1'b0;
        Branch_i   = 1'b0;
        PC_Write_i = pcw;
        sb_q.push_back({imem(exp_pc), exp_pc});
        if (pcw) exp_pc = exp_pc + 32'd4;
        step();
        e = sb_q.pop_front();
        exp_id_instr = e[63:32];
        exp_id_pc    = e[31:0];
        checks++;
        if (ID_Instr_o !== exp_id_instr) begin
            errors++;
            $display("FAIL adv_instr: got %h expected %h", ID_Instr_o, exp_id_instr);
        end
        checks++;
        if (ID_PC_o !== exp_id_pc || ID_Valid_o !== 1'b1) begin
            errors++;
            $display("FAIL adv_idpc: got %h/%b expected %h/1", ID_PC_o, ID_Valid_o, exp_id_pc);
        end
        checks++;
        if (PC_o !== exp_pc) begin
            errors++;
            $display("FAIL adv_pc: got %h expected %h", PC_o, exp_pc);
        end
    endtask

    task automatic check_flushed(input string name);
        checks++;
        if (PC_o !== exp_pc || ID_Instr_o !== 32'h13 || ID_Valid_o !== 1'b0 ||
            ID_PC_o !== exp_id_pc || Flush_cnt_o !== exp_flush) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h v=%b idpc=%h fl=%0d expected pc=%h instr=00000013 v=0 idpc=%h fl=%0d",
                     name, PC_o, ID_Instr_o, ID_Valid_o, ID_PC_o, Flush_cnt_o, exp_pc, exp_id_pc, exp_flush);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; PC_Write_i = 1'b1; Stall_i = 1'b0; Branch_i = 1'b0;
        Branch_target_i = 32'h0;
        repeat (3) step();
        checks++;
        if (PC_o !== 32'h0 || ID_Valid_o !== 1'b0 || ID_Instr_o !== 32'h13 || ID_PC_o !== 32'h0 ||
            Stall_cnt_o !== 16'h0 || Flush_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_vals: got pc=%h v=%b instr=%h idpc=%h st=%0d fl=%0d expected 0/0/13/0/0/0",
                     PC_o, ID_Valid_o, ID_Instr_o, ID_PC_o, Stall_cnt_o, Flush_cnt_o);
        end
        exp_pc = 32'h0; exp_stall = 16'h0; exp_flush = 16'h0;
        rst_i = 1'b1;
        repeat (3) advance(1'b1);
        checks++;
        if (PC_o !== 32'hC || ID_PC_o !== 32'h8 || ID_Valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got pc=%h idpc=%h v=%b expected c/8/1", PC_o, ID_PC_o, ID_Valid_o);
        end
    endtask

    task automatic test_load_use();
        advance(1'b1);
        Stall_i = 1'b1; PC_Write_i = 1'b0;
        exp_stall = exp_stall + 16'd1;
        step();
        checks++;
        if (PC_o !== 32'h10 || ID_Instr_o !== exp_id_instr || ID_PC_o !== exp_id_pc ||
            ID_Valid_o !== 1'b1 || Stall_cnt_o !== exp_stall) begin
            errors++;
            $display("FAIL load_use: got pc=%h instr=%h idpc=%h v=%b st=%0d expected pc=10 instr=%h idpc=%h v=1 st=%0d",
                     PC_o, ID_Instr_o, ID_PC_o, ID_Valid_o, Stall_cnt_o, exp_id_instr, exp_id_pc, exp_stall);
        end
        advance(1'b1);
        checks++;
        if (PC_o !== 32'h14 || ID_PC_o !== 32'h10) begin
            errors++;
            $display("FAIL load_use_resume: got pc=%h idpc=%h expected 14/10", PC_o, ID_PC_o);
        end
    endtask

    task automatic test_branch();
        advance(1'b1);
        Stall_i = 1'b0; Branch_i = 1'b1; PC_Write_i = 1'b1; Branch_target_i = 32'h40;
        exp_id_pc = exp_pc; exp_pc = 32'h40; exp_flush = exp_flush + 16'd1;
        step();
        check_flushed("branch");
    endtask

    task automatic test_stall_branch();
        Stall_i = 1'b1; Branch_i = 1'b1; PC_Write_i = 1'b0; Branch_target_i = 32'h80;
        exp_stall = exp_stall + 16'd1;
        step();
        check_flushed("stall_branch");
        checks++;
        if (Stall_cnt_o !== exp_stall) begin
            errors++;
            $display("FAIL stall_branch_cnt: got %0d expected %0d", Stall_cnt_o, exp_stall);
        end
        Stall_i = 1'b0; Branch_i = 1'b1; PC_Write_i = 1'b0;
        exp_id_pc = exp_pc; exp_flush = exp_flush + 16'd1;
        step();
        check_flushed("branch_nopcw");
    endtask

    task automatic test_misaligned_wrap();
        Stall_i = 1'b0; Branch_i = 1'b1; PC_Write_i = 1'b1; Branch_target_i = 32'h43;
        exp_id_pc = exp_pc; exp_pc = 32'h40; exp_flush = exp_flush + 16'd1;
        step();
        check_flushed("misaligned");
        Branch_target_i = 32'hFFFF_FFFE;
        exp_id_pc = exp_pc; exp_pc = 32'hFFFF_FFFC; exp_flush = exp_flush + 16'd1;
        step();
        check_flushed("to_top");
        advance(1'b1);
        checks++;
        if (PC_o !== 32'h0 || ID_PC_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap: got pc=%h idpc=%h expected 0/fffffffc", PC_o, ID_PC_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) advance(1'($urandom_range(0, 3) != 0));
        Stall_i = 1'b1; Branch_i = 1'b0; PC_Write_i = 1'b1;
        exp_pc = exp_pc + 32'd4; exp_stall = exp_stall + 16'd1;
        step();
        checks++;
        if (PC_o !== exp_pc || ID_PC_o !== exp_id_pc || Stall_cnt_o !== exp_stall) begin
            errors++;
            $display("FAIL stall_pcw: got pc=%h idpc=%h st=%0d expected %h/%h/%0d",
                     PC_o, ID_PC_o, Stall_cnt_o, exp_pc, exp_id_pc, exp_stall);
        end
        for (int i = 0; i < 4; i++) advance(1'b1);
    endtask

    task automatic test_saturation();
        Stall_i = 1'b1; Branch_i = 1'b0; PC_Write_i = 1'b0;
        repeat (65536 + 3) step();
        checks++;
        if (Stall_cnt_o !== 16'hFFFF || PC_o !== exp_pc || Flush_cnt_o !== exp_flush) begin
            errors++;
            $display("FAIL saturation: got st=%h pc=%h fl=%0d expected ffff/%h/%0d",
                     Stall_cnt_o, PC_o, Flush_cnt_o, exp_pc, exp_flush);
        end
    endtask

    task automatic test_reset_mid();
        Stall_i = 1'b1; Branch_i = 1'b1; PC_Write_i = 1'b1; Branch_target_i = 32'h100;
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (PC_o !== 32'h0 || ID_Valid_o !== 1'b0 || ID_Instr_o !== 32'h13 || ID_PC_o !== 32'h0 ||
            Stall_cnt_o !== 16'h0 || Flush_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: got pc=%h v=%b instr=%h idpc=%h st=%0d fl=%0d expected 0/0/13/0/0/0",
                     PC_o, ID_Valid_o, ID_Instr_o, ID_PC_o, Stall_cnt_o, Flush_cnt_o);
        end
        step();
        rst_i = 1'b1;
        sb_q.delete();
        exp_pc = 32'h0;
        advance(1'b1);
        checks++;
        if (PC_o !== 32'h4 || ID_PC_o !== 32'h0 || Stall_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_adv: got pc=%h idpc=%h st=%0d expected 4/0/0", PC_o, ID_PC_o, Stall_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_stall_branch();
        test_misaligned_wrap();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
